// File: rtl/cpu_pkg.sv
// cpu_pkg: shared arbiter state encoding and default bus widths
package cpu_pkg;
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} arb_state_t;
   localparam int CPU_AW = 16;
   localparam int CPU_DW = 16;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared port
interface mem_port_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_done;
   logic [DW-1:0] if_rdata;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_done;
   logic [DW-1:0] dm_rdata;
   logic          stall_if;
   logic          stall_mem;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_rd;
   logic          mem_wr;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;
   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
      output if_done, if_rdata, dm_done, dm_rdata, stall_if, stall_mem,
             mem_addr, mem_wdata, mem_rd, mem_wr
   );
   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
      input  if_done, if_rdata, dm_done, dm_rdata, stall_if, stall_mem,
             mem_addr, mem_wdata, mem_rd, mem_wr
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data accesses;
// data wins by default, a starvation counter eventually forces fetch through.
module mem_port_arbiter
   import cpu_pkg::*;
#(
   parameter int AW         = CPU_AW,
   parameter int DW         = CPU_DW,
   parameter int STARVE_MAX = 3
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);
   arb_state_t    state, state_nx;
   logic [3:0]    starve_cnt;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q, if_rdata_q, dm_rdata_q;
   logic          rd_q, wr_q, if_done_q, dm_done_q;
   logic          grant_if, grant_dm, finish;
   always_comb begin
      state_nx = state;
      grant_if = 1'b0;
      grant_dm = 1'b0;
      finish   = 1'b0;
      if (state == IDLE) begin
         grant_dm = bus.dm_req && (starve_cnt < SMAX || !bus.if_req);
         grant_if = bus.if_req && !grant_dm;
         state_nx = grant_dm ? BUSY_DM : grant_if ? BUSY_IF : IDLE;
      end else begin
         finish   = bus.mem_ready;
         state_nx = bus.mem_ready ? IDLE : state;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         if_done_q  <= 1'b0;
         dm_done_q  <= 1'b0;
      end else begin
         state     <= state_nx;
         if_done_q <= finish && state == BUSY_IF;
         dm_done_q <= finish && state == BUSY_DM;
         // fetch waiting while not owning the port ages toward a forced grant
         if (grant_if)
            starve_cnt <= '0;
         else if (bus.if_req && state != BUSY_IF && starve_cnt < SMAX)
            starve_cnt <= starve_cnt + 4'd1;
         if (grant_if) begin
            addr_q <= bus.if_addr;
            rd_q   <= 1'b1;
         end
         if (grant_dm) begin
            addr_q <= bus.dm_addr;
            rd_q   <= !bus.dm_we;
            wr_q   <= bus.dm_we;
            if (bus.dm_we)
               wdata_q <= bus.dm_wdata;
         end
         if (finish) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            if (state == BUSY_IF)
               if_rdata_q <= bus.mem_rdata;
            if (state == BUSY_DM && !wr_q)
               dm_rdata_q <= bus.mem_rdata;
         end
      end
   end
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_rd    = rd_q;
   assign bus.mem_wr    = wr_q;
   assign bus.if_done   = if_done_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_done   = dm_done_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.stall_if  = bus.if_req & ~if_done_q;
   assign bus.stall_mem = bus.dm_req & ~dm_done_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the CPU's single memory port between the fetch stage (instruction reads) and the memory stage (data loads and stores). It drives registered address and strobes to memory and tolerates wait states through `mem_ready`. It returns read data with a one-cycle `*_done` pulse and raises stall signals so the pipeline control can freeze the losing stage. Data accesses win by default; a starvation counter guarantees that fetch eventually gets the port.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 16, data width
- `STARVE_MAX`, 3, consecutive fetch-denied cycles before fetch is forced to win (range 1..15)

Ports:
- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `if_req` in 1: fetch requests an instruction read; held high until `if_done`
- `if_addr` in AW: fetch address; stable while `if_req` is high
- `if_done` out 1: one-cycle pulse; `if_rdata` is valid
- `if_rdata` out DW: instruction word
- `dm_req` in 1: memory stage requests an access; held high until `dm_done`
- `dm_we` in 1: 1 = store, 0 = load
- `dm_addr` in AW: data address
- `dm_wdata` in DW: store data
- `dm_done` out 1: one-cycle pulse; `dm_rdata` is valid for loads
- `dm_rdata` out DW: load data
- `stall_if` out 1: fetch must hold; combinational
- `stall_mem` out 1: memory stage must hold; combinational
- `mem_addr` out AW: registered
- `mem_wdata` out DW: registered
- `mem_rd` out 1: registered
- `mem_wr` out 1: registered
- `mem_ready` in 1: memory completes the current access this cycle
- `mem_rdata` in DW: valid when `mem_ready` is high

## Operation
- The state machine has three states: IDLE, BUSY_IF and BUSY_DM.
- IDLE arbitration, evaluated every cycle:
  - if `dm_req` and `starve_cnt < STARVE_MAX`, go to BUSY_DM;
  - else if `if_req`, go to BUSY_IF;
  - else if `dm_req`, go to BUSY_DM;
  - otherwise stay in IDLE.
- On a grant, the arbiter latches the granted requester's address into `mem_addr`. For a data store it also latches `dm_wdata` into `mem_wdata` and sets `mem_wr`. For a fetch or a load it sets `mem_rd`.
- In BUSY_x, the outputs stay frozen until `mem_ready` is sampled high. On that edge:
  - drop `mem_rd` and `mem_wr`;
  - register `mem_rdata` into the granted requester's `*_rdata`;
  - pulse that requester's `*_done` in the next cycle;
  - return to IDLE.
- `starve_cnt` is a 4-bit counter:
  - it increments, saturating at STARVE_MAX, on every cycle where `if_req` is high and fetch is not granted and not in flight;
  - it clears when fetch is granted.
- `stall_if` = `if_req` & ~`if_done`. `stall_mem` = `dm_req` & ~`dm_done`.
- `*_rdata` holds its last value between accesses. `dm_rdata` is not updated for stores.

## Timing
- Reset values:
  - state = IDLE and `starve_cnt` = 0;
  - `mem_rd`, `mem_wr`, `if_done` and `dm_done` = 0;
  - `mem_addr`, `mem_wdata`, `if_rdata` and `dm_rdata` = 0.
- Latency: if a request is sampled in IDLE at edge 0, `mem_rd`/`mem_wr` are high in cycle 1. If `mem_ready` is high in cycle 1, `*_done` is high in cycle 2. Each wait state adds one cycle.
- Throughput: after a `*_done` the arbiter returns to IDLE, so there is at least one idle cycle between accesses. The maximum rate is one access every 2 cycles.
- Simultaneous requests in IDLE: data wins unless `starve_cnt == STARVE_MAX`.
- A request that drops before its grant is simply not served. A request that drops after its grant still completes, and its `*_done` still pulses.
- Reset mid-access: at the next edge, `mem_rd`/`mem_wr` drop and the state returns to IDLE. No `*_done` is produced for the aborted access.
- Stores complete on `mem_ready` exactly like loads.

## Structure
- A shared package `cpu_pkg` holds:
  - the `arb_state_t` enum {IDLE, BUSY_IF, BUSY_DM};
  - the AW/DW defaults.
- A single module; no sub-module is needed. The starvation counter is kept inline.

## Test plan
- Single fetch: `if_addr`=0x0040, `mem_ready` tied high → `mem_rd`=1 with `mem_addr`=0x0040 in cycle 1; `if_done`=1 with `if_rdata`=`mem_rdata` in cycle 2.
- Store with 2 wait states: `dm_we`=1, `dm_addr`=0x1000, `dm_wdata`=0xBEEF → `mem_wr` is high for 3 cycles with `mem_wdata`=0xBEEF, then `dm_done` pulses once.
- Collision: `if_req` and `dm_req` rise in the same cycle → the data access is served first, then the fetch; `stall_if` stays high throughout.
- Starvation: `dm_req` held continuously and `if_req` held, `STARVE_MAX`=3 → fetch is granted once `starve_cnt` reaches 3; `starve_cnt` returns to 0.
- Reset during BUSY_DM with `mem_ready` low → next cycle `mem_wr`=0, state=IDLE, no `dm_done` pulse.
- Wait-state load: `dm_we`=0 with `mem_ready` low for 4 cycles → `dm_rdata` captures `mem_rdata` only from the ready cycle; `dm_done` pulses exactly once.
